tdm_demux_1to8: RTL and testbench
=================================

TDM_DEMUX_1TO8 -- requirements
Module: tdm_demux_1to8

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16 (legal range 2..255): the number of consecutive cycles without din_valid in COLLECT that aborts a frame.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port din, input, 1 bit: serial TDM data, one slot per accepted beat.
REQ-005 The block SHALL have port din_valid, input, 1 bit: din carries a slot bit this cycle.
REQ-006 The block SHALL have port frame_start, input, 1 bit: qualified by din_valid; marks that the beat is slot 0.
REQ-007 The block SHALL have port Q, output, 8 bits: the last complete frame, with Q[k] = bit received in slot k.
REQ-008 The block SHALL have port frame_valid, output, 1 bit: one-cycle pulse when Q is updated.
REQ-009 The block SHALL have port sync_err, output, 1 bit: one-cycle pulse on a frame resync or timeout abort.
REQ-010 The block SHALL have port sel, output, 3 bits: the slot index the next accepted beat will be written to.
REQ-011 The block SHALL have port busy, output, 1 bit: high while the state is COLLECT.

Function
REQ-012 The block SHALL implement two states, IDLE and COLLECT, with an internal 7-bit shadow register, a 3-bit slot counter (driving sel) and an 8-bit timeout counter.
REQ-013 In IDLE, when din_valid=1 and frame_start=1, the block SHALL write shadow[0]=din, set slot=1, clear the timeout counter, and go to COLLECT.
REQ-014 In IDLE, when din_valid=1 and frame_start=0, the block SHALL ignore the beat: no state change, no output change.
REQ-015 In COLLECT, when din_valid=1, frame_start=0 and slot<7, the block SHALL write shadow[slot]=din, increment slot, and clear the timeout counter.
REQ-016 In COLLECT, when din_valid=1, frame_start=0 and slot=7, the block SHALL, on the same edge, load Q={din, shadow[6:0]}, pulse frame_valid for exactly one cycle, set slot=0, and go to IDLE.
REQ-017 Q and frame_valid SHALL be registered: both are visible in the cycle immediately after the edge that accepts the slot-7 beat, and a frame_start beat in that next cycle SHALL be accepted (back-to-back frames, zero gap).
REQ-018 In COLLECT, when din_valid=1 and frame_start=1, the block SHALL pulse sync_err, restart the frame (shadow[0]=din, slot=1, timeout cleared), remain in COLLECT, and leave Q unchanged.
REQ-019 In COLLECT, each cycle with din_valid=0 SHALL increment the timeout counter; when it reaches TIMEOUT-1 with din_valid=0, the block SHALL pulse sync_err, set slot=0, and go to IDLE, leaving Q unchanged.
REQ-020 The partial frame SHALL never appear on Q; Q changes only per REQ-016.
REQ-021 frame_valid and sync_err SHALL never be asserted in the same cycle, and each SHALL be high for at most one cycle per event.
REQ-022 The slot counter SHALL never wrap inside COLLECT; reaching slot 7 is terminal per REQ-016.
REQ-023 The timeout counter SHALL saturate and SHALL be held at 0 in IDLE.

Reset
REQ-024 While rst=1, regardless of clk, the block SHALL force state=IDLE, Q=8'h00, frame_valid=0, sync_err=0, sel=3'd0, busy=0, timeout counter=0, and shadow=0.
REQ-025 Reset asserted mid-frame SHALL discard the partial frame; after deassertion, the first accepted beat SHALL require frame_start=1.

Verification
REQ-026 Reset, then send 8 consecutive beats carrying bits of 8'hA5 (slot 0 first, frame_start on slot 0) -> busy=1 during beats 1-7, Q=8'hA5 and frame_valid=1 for exactly one cycle after beat 8, sync_err=0.
REQ-027 Back-to-back frames 8'h3C then 8'hC3 with no gap cycles -> two frame_valid pulses 8 cycles apart, with Q=8'h3C then Q=8'hC3.
REQ-028 Send 4 beats of a frame, then a frame_start beat, then 7 more beats of 8'h81 -> one sync_err pulse at the resync, then Q=8'h81 with frame_valid; Q holds its prior value until then.
REQ-029 With TIMEOUT=4, send 3 beats, then hold din_valid=0 -> sync_err pulse after the 4th idle cycle, busy=0, sel=0, Q unchanged; the next non-frame_start beat is ignored.
REQ-030 With Q=8'h5A, assert rst asynchronously mid-frame at slot 5 -> Q=8'h00, sel=0, busy=0 immediately, with no frame_valid pulse after release.
REQ-031 Send din_valid beats with frame_start=0 in IDLE -> no output change, sel stays 0.

Source files
------------

// File: rtl/tdm_demux_1to8.sv
// Serial TDM 1-to-8 demultiplexer: gathers eight slot bits into a shadow register
// and publishes them on Q as one registered frame, with resync and idle-timeout aborts.
module tdm_demux_1to8 #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic       din_valid,
  input  logic       frame_start,
  output logic [7:0] Q,
  output logic       frame_valid,
  output logic       sync_err,
  output logic [2:0] sel,
  output logic       busy
);

  typedef enum logic {IDLE, COLLECT} state_t;

  localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [6:0] shadow, shadow_nxt;
  logic [2:0] slot, slot_nxt;
  logic [7:0] tcnt, tcnt_nxt;
  logic [7:0] q_nxt;
  logic       fv_nxt, se_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      shadow      <= '0;
      slot        <= '0;
      tcnt        <= '0;
      Q           <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      state       <= state_nxt;
      shadow      <= shadow_nxt;
      slot        <= slot_nxt;
      tcnt        <= tcnt_nxt;
      Q           <= q_nxt;
      frame_valid <= fv_nxt;
      sync_err    <= se_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    shadow_nxt = shadow;
    slot_nxt   = slot;
    tcnt_nxt   = tcnt;
    q_nxt      = Q;
    fv_nxt     = 1'b0;
    se_nxt     = 1'b0;
    case (state)
      IDLE: begin
        tcnt_nxt = '0;
        if (din_valid && frame_start) begin
          shadow_nxt[0] = din;
          slot_nxt      = 3'd1;
          state_nxt     = COLLECT;
        end
      end
      COLLECT: begin
        if (din_valid) begin
          tcnt_nxt = '0;
          if (frame_start) begin
            // A new slot 0 mid-frame restarts collection; the partial frame is dropped.
            se_nxt        = 1'b1;
            shadow_nxt[0] = din;
            slot_nxt      = 3'd1;
          end else if (slot == 3'd7) begin
            q_nxt     = {din, shadow};
            fv_nxt    = 1'b1;
            slot_nxt  = 3'd0;
            state_nxt = IDLE;
          end else begin
            for (int k = 0; k < 7; k++)
              if (slot == 3'(k)) shadow_nxt[k] = din;
            slot_nxt = slot + 3'd1;
          end
        end else if (tcnt == TLAST) begin
          se_nxt    = 1'b1;
          slot_nxt  = 3'd0;
          tcnt_nxt  = '0;
          state_nxt = IDLE;
        end else if (tcnt != 8'hFF) begin
          tcnt_nxt = tcnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign sel  = slot;
  assign busy = (state == COLLECT);

endmodule

// File: tb/tb_tdm_demux_1to8.sv
// Scoreboard bench for tdm_demux_1to8: a frame-level reference model queues expected
// frames, sync errors and per-cycle visible state; a negedge monitor pops and compares.
module tb_tdm_demux_1to8;
  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din = 1'b0, din_valid = 1'b0, frame_start = 1'b0;
  logic [7:0] Q;
  logic       frame_valid, sync_err, busy;
  logic [2:0] sel;

  tdm_demux_1to8 #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .frame_start(frame_start),
    .Q(Q), .frame_valid(frame_valid), .sync_err(sync_err), .sel(sel), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int stamp; logic [7:0] v; } ev_t;
  typedef struct { int stamp; logic [7:0] q; logic [2:0] sel; logic busy; } st_t;

  ev_t frameq[$];
  ev_t errq[$];
  st_t stq[$];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  // reference model state, kept as a list of received slot bits
  bit         in_frame = 0;
  bit         bits[$];
  int         idle = 0;
  logic [7:0] last_q = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic model_reset();
    in_frame = 0;
    bits.delete();
    idle = 0;
    last_q = 8'h00;
    frameq.delete();
    errq.delete();
    stq.delete();
  endtask

  task automatic model_step(input bit dv, input bit fs, input bit d, input int stamp);
    ev_t e;
    st_t s;
    logic [7:0] f;
    e.stamp = stamp;
    e.v = 8'h00;
    if (!in_frame) begin
      if (dv && fs) begin
        in_frame = 1;
        bits.delete();
        bits.push_back(d);
        idle = 0;
      end
    end else if (dv) begin
      idle = 0;
      if (fs) begin
        errq.push_back(e);
        bits.delete();
        bits.push_back(d);
      end else begin
        bits.push_back(d);
        if (bits.size() == 8) begin
          for (int k = 0; k < 8; k++) f[k] = bits[k];
          e.v = f;
          frameq.push_back(e);
          last_q = f;
          in_frame = 0;
          bits.delete();
        end
      end
    end else begin
      idle++;
      if (idle == TO) begin
        errq.push_back(e);
        in_frame = 0;
        bits.delete();
      end
    end
    s.stamp = stamp;
    s.q = last_q;
    s.sel = in_frame ? 3'(bits.size()) : 3'd0;
    s.busy = in_frame;
    stq.push_back(s);
  endtask

  // drive one cycle; called at posedge+1, returns at the next posedge+1
  task automatic beat(input bit dv, input bit fs, input bit d);
    din_valid = dv;
    frame_start = fs;
    din = d;
    model_step(dv, fs, d, cyc + 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] v);
    for (int k = 0; k < 8; k++) beat(1'b1, k == 0, v[k]);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      if (frame_valid && sync_err) chk("fv_se_exclusive", 1, 0);
      while (frameq.size() > 0 && frameq[0].stamp < cyc) begin
        chk("frame_valid_missing", 0, 1);
        void'(frameq.pop_front());
      end
      while (errq.size() > 0 && errq[0].stamp < cyc) begin
        chk("sync_err_missing", 0, 1);
        void'(errq.pop_front());
      end
      if (frame_valid) begin
        if (frameq.size() == 0) chk("frame_valid_unexpected", 1, 0);
        else begin
          ev_t e;
          e = frameq.pop_front();
          chk("frame_cycle", cyc, e.stamp);
          chk("frame_q", Q, e.v);
        end
      end
      if (sync_err) begin
        if (errq.size() == 0) chk("sync_err_unexpected", 1, 0);
        else begin
          ev_t e;
          e = errq.pop_front();
          chk("sync_err_cycle", cyc, e.stamp);
        end
      end
      while (stq.size() > 0 && stq[0].stamp < cyc) void'(stq.pop_front());
      if (stq.size() > 0 && stq[0].stamp == cyc) begin
        st_t s;
        s = stq.pop_front();
        chk("q_hold", Q, s.q);
        chk("sel", sel, s.sel);
        chk("busy", busy, s.busy);
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_q", Q, 8'h00);
    chk("rst_sel", sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fv", frame_valid, 0);
    chk("rst_se", sync_err, 0);
    rst = 1'b0;
    model_reset();
    chk_en = 1;
    beat(0, 0, 0);

    // ignored beats in IDLE
    for (int k = 0; k < 4; k++) beat(1, 0, k[0]);
    // single frame and back-to-back frames
    send_frame(8'hA5);
    beat(0, 0, 0);
    send_frame(8'h3C);
    send_frame(8'hC3);
    // resync: 4 beats, then a fresh frame 8'h81
    for (int k = 0; k < 4; k++) beat(1, k == 0, 1'b1);
    send_frame(8'h81);
    // timeout after 3 beats, then an ignored beat
    for (int k = 0; k < 3; k++) beat(1, k == 0, 1'b0);
    repeat (TO + 1) beat(0, 0, 0);
    beat(1, 0, 1);
    beat(0, 0, 0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 39) == 0) repeat (TO + 1) beat(0, 0, 0);
      else begin
        bit dv, fs;
        dv = ($urandom_range(0, 7) != 0);
        fs = in_frame ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 1) == 1);
        beat(dv, fs, 1'($urandom));
      end
    end
    beat(0, 0, 0);
    beat(0, 0, 0);

    // asynchronous reset at slot 5 with Q = 8'h5A
    send_frame(8'h5A);
    for (int k = 0; k < 5; k++) beat(1, k == 0, 1'b1);
    #1;
    chk("q_before_arst", Q, 8'h5A);
    chk("sel_before_arst", sel, 5);
    chk_en = 0;
    #1;
    rst = 1'b1;
    #1;
    chk("arst_q", Q, 8'h00);
    chk("arst_sel", sel, 0);
    chk("arst_busy", busy, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    din_valid = 1'b0;
    frame_start = 1'b0;
    model_reset();
    chk_en = 1;
    // finishing the interrupted frame without frame_start must be ignored
    for (int k = 0; k < 3; k++) beat(1, 0, 1);
    repeat (3) beat(0, 0, 0);

    chk("frameq_left", frameq.size(), 0);
    chk("errq_left", errq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
